vertex_project: RTL and testbench
=================================

VERTEX_PROJECT -- requirements
Module: vertex_project

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- FOCAL, 256: focal length in pixels, unsigned integer 1..32767.
- SCREEN_W, 320: screen width in pixels.
- SCREEN_H, 240: screen height in pixels.
- NEAR_Z, 32'h0000_4000: near-plane depth, signed Q16.16.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk, in, 1: sole clock, rising edge.
- i_rst_n, in, 1: reset, asynchronous, active-low.
- i_valid, in, 1: input vertex valid.
- o_ready, out, 1: block can accept a vertex.
- i_x, in, 32: camera-space x, signed Q16.16.
- i_y, in, 32: camera-space y, signed Q16.16.
- i_z, in, 32: camera-space depth, signed Q16.16.
- o_div_start, out, 1: one-cycle start pulse to the signed 32-bit divider.
- o_div_dividend, out, 32: signed dividend.
- o_div_divisor, out, 32: signed divisor.
- i_div_quotient, in, 32: signed quotient, truncated toward zero.
- i_div_done, in, 1: one-cycle quotient-valid pulse.
- o_valid, out, 1: projected vertex valid.
- i_ready, in, 1: downstream accepts the vertex.
- o_sx, out, 16: signed screen x.
- o_sy, out, 16: signed screen y.
- o_z, out, 32: captured i_z passthrough.
- o_clip, out, 1: vertex is near-clipped or off-screen.

Function
REQ-003 FSM states SHALL be IDLE, DIV_X, WAIT_X, DIV_Y, WAIT_Y, OUT.
REQ-004 In IDLE, o_ready SHALL be 1; in all other states it SHALL be 0.
REQ-005 On i_valid && o_ready, i_x, i_y and i_z SHALL be captured.
- If captured z < NEAR_Z (signed compare), the FSM SHALL go to OUT with o_sx=0, o_sy=0, o_clip=1, and no divide SHALL be issued.
- Otherwise the FSM SHALL go to DIV_X.
REQ-006 Dividend SHALL be the 48-bit signed product coord*FOCAL, saturated to [-(2^31-1), 2^31-1]. The value -2^31 SHALL never be driven.
REQ-007 Divisor SHALL be the captured z.
REQ-008 In DIV_X and DIV_Y, o_div_start SHALL pulse high for exactly one cycle with the dividend and divisor valid in that cycle. The FSM SHALL then move to WAIT_X or WAIT_Y respectively.
REQ-009 Dividend and divisor SHALL hold stable until the matching i_div_done.
REQ-010 No divider latency SHALL be assumed.
REQ-011 i_div_done outside WAIT_X and WAIT_Y SHALL be ignored.
REQ-012 In WAIT_X, on i_div_done: sx32 = SCREEN_W/2 + quotient, computed in 33-bit signed arithmetic. The FSM SHALL then go to DIV_Y.
REQ-013 In WAIT_Y, on i_div_done: sy32 = SCREEN_H/2 - quotient, computed in 33-bit signed arithmetic. The FSM SHALL then go to OUT.
REQ-014 o_sx and o_sy SHALL be sx32 and sy32 saturated to [-32768, 32767].
REQ-015 o_clip SHALL be 1 when sx32 is outside [0, SCREEN_W-1] or sy32 is outside [0, SCREEN_H-1], evaluated before saturation.
REQ-016 In OUT, o_valid SHALL be 1. o_sx, o_sy, o_z and o_clip SHALL hold stable while i_ready is 0.
REQ-017 On o_valid && i_ready, the FSM SHALL return to IDLE next cycle with o_valid=0.
REQ-018 Non-clipped latency from accept to o_valid SHALL be 2 divider round trips + 3 cycles.
REQ-019 Near-clipped latency from accept to o_valid SHALL be 1 cycle.

Reset
REQ-020 While i_rst_n=0, asynchronously and at any state:
- state SHALL be IDLE.
- o_ready SHALL be 1.
- o_valid, o_div_start, o_clip SHALL be 0.
- o_sx, o_sy, o_z, o_div_dividend, o_div_divisor SHALL be 0.
REQ-021 A divider result pending at reset SHALL be discarded.

Verification
REQ-022 x=0x0001_0000, y=0x0000_8000, z=0x0002_0000 -> dividends 0x0100_0000 and 0x0080_0000; o_sx=288, o_sy=56, o_clip=0.
REQ-023 x=0xFFFF_0000 (-1.0), y=0, z=0x0002_0000 -> quotient -128; o_sx=32, o_sy=120, o_clip=0.
REQ-024 z=0x0000_1000 -> o_clip=1, o_sx=o_sy=0, o_div_start never asserted, o_valid 1 cycle after accept.
REQ-025 x=0x7FFF_FFFF, z=0x0001_0000 -> dividend 0x7FFF_FFFF, o_sx=32767, o_clip=1. Separately, x=0x0002_0000, z=0x0001_0000 -> o_sx=672, o_clip=1.
REQ-026 Hold i_ready=0 for 10 cycles in OUT -> outputs stable, o_ready=0; i_ready=1 -> o_ready=1 on the next cycle.
REQ-027 Drop i_rst_n in WAIT_X, then pulse i_div_done after release -> block in IDLE, done ignored, no o_valid.

Source files
------------

// File: rtl/vertex_project.sv
// Perspective projection of one camera-space vertex to screen coordinates,
// issuing the x and y perspective divides to an external shared signed divider.
module vertex_project #(
   parameter int                 FOCAL    = 256,
   parameter int                 SCREEN_W = 320,
   parameter int                 SCREEN_H = 240,
   parameter logic signed [31:0] NEAR_Z   = 32'sh0000_4000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [31:0] i_x,
   input  logic [31:0] i_y,
   input  logic [31:0] i_z,
   output logic        o_div_start,
   output logic [31:0] o_div_dividend,
   output logic [31:0] o_div_divisor,
   input  logic [31:0] i_div_quotient,
   input  logic        i_div_done,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_sx,
   output logic [15:0] o_sy,
   output logic [31:0] o_z,
   output logic        o_clip
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] DIV_X  = 3'd1;
   localparam logic [2:0] WAIT_X = 3'd2;
   localparam logic [2:0] DIV_Y  = 3'd3;
   localparam logic [2:0] WAIT_Y = 3'd4;
   localparam logic [2:0] OUT    = 3'd5;

   localparam logic signed [32:0] HALF_W   = 33'(SCREEN_W / 2);
   localparam logic signed [32:0] HALF_H   = 33'(SCREEN_H / 2);
   localparam logic signed [32:0] MAX_X    = 33'(SCREEN_W - 1);
   localparam logic signed [32:0] MAX_Y    = 33'(SCREEN_H - 1);
   localparam logic signed [32:0] SAT_HI   = 33'sd32767;
   localparam logic signed [32:0] SAT_LO   = -33'sd32768;
   localparam logic signed [47:0] PROD_MAX = 48'sh0000_7FFF_FFFF;
   localparam logic signed [47:0] PROD_MIN = -PROD_MAX;
   localparam logic signed [47:0] FOCAL_W  = 48'(FOCAL);

   // Symmetric clamp keeps -2^31 off the divider bus.
   function automatic logic [31:0] scale_sat(input logic signed [31:0] coord);
      logic signed [47:0] prod;
      prod = 48'(coord) * FOCAL_W;
      if (prod > PROD_MAX)
         scale_sat = 32'h7FFF_FFFF;
      else if (prod < PROD_MIN)
         scale_sat = 32'h8000_0001;
      else
         scale_sat = prod[31:0];
   endfunction

   function automatic logic [15:0] sat16(input logic signed [32:0] v);
      if (v > SAT_HI)
         sat16 = 16'h7FFF;
      else if (v < SAT_LO)
         sat16 = 16'h8000;
      else
         sat16 = v[15:0];
   endfunction

   logic [2:0]         state;
   logic [31:0]        y_cap;
   logic               clip_x;
   logic signed [32:0] quo_w;
   logic signed [32:0] sx_next;
   logic signed [32:0] sy_next;

   assign quo_w   = 33'($signed(i_div_quotient));
   assign sx_next = HALF_W + quo_w;
   assign sy_next = HALF_H - quo_w;

   assign o_ready     = (state == IDLE);
   assign o_valid     = (state == OUT);
   assign o_div_start = (state == DIV_X) || (state == DIV_Y);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= IDLE;
         o_div_dividend <= '0;
         o_div_divisor  <= '0;
         o_sx           <= '0;
         o_sy           <= '0;
         o_z            <= '0;
         o_clip         <= 1'b0;
         y_cap          <= '0;
         clip_x         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  o_z   <= i_z;
                  y_cap <= i_y;
                  if ($signed(i_z) < NEAR_Z) begin
                     o_sx   <= '0;
                     o_sy   <= '0;
                     o_clip <= 1'b1;
                     state  <= OUT;
                  end else begin
                     o_div_dividend <= scale_sat(i_x);
                     o_div_divisor  <= i_z;
                     state          <= DIV_X;
                  end
               end
            end
            DIV_X: state <= WAIT_X;
            WAIT_X: begin
               if (i_div_done) begin
                  o_sx           <= sat16(sx_next);
                  clip_x         <= (sx_next < 33'sd0) || (sx_next > MAX_X);
                  o_div_dividend <= scale_sat(y_cap);
                  state          <= DIV_Y;
               end
            end
            DIV_Y: state <= WAIT_Y;
            // Clip flag combines both axes, judged on the unsaturated sums.
            WAIT_Y: begin
               if (i_div_done) begin
                  o_sy   <= sat16(sy_next);
                  o_clip <= clip_x || (sy_next < 33'sd0) || (sy_next > MAX_Y);
                  state  <= OUT;
               end
            end
            OUT: begin
               if (i_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vertex_project.sv
// Randomized bench for vertex_project: emulated divider, per-cycle compare
// against an arithmetic projection model, and literal pins on directed vertices.
module tb_vertex_project;

   localparam int                 FOCAL = 256;
   localparam int                 SW    = 320;
   localparam int                 SH    = 240;
   localparam logic signed [31:0] NEAR  = 32'sh0000_4000;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_x, i_y, i_z;
   logic        o_div_start;
   logic [31:0] o_div_dividend, o_div_divisor;
   logic [31:0] i_div_quotient;
   logic        i_div_done;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_sx, o_sy;
   logic [31:0] o_z;
   logic        o_clip;

   always #5 i_clk = ~i_clk;

   vertex_project #(.FOCAL(FOCAL), .SCREEN_W(SW), .SCREEN_H(SH), .NEAR_Z(NEAR)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_x(i_x), .i_y(i_y), .i_z(i_z),
      .o_div_start(o_div_start), .o_div_dividend(o_div_dividend),
      .o_div_divisor(o_div_divisor), .i_div_quotient(i_div_quotient),
      .i_div_done(i_div_done), .o_valid(o_valid), .i_ready(i_ready),
      .o_sx(o_sx), .o_sy(o_sy), .o_z(o_z), .o_clip(o_clip)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Driver-to-checker handshake for literal expectations on directed vertices.
   logic        pin_on = 1'b0;
   logic        pin_dchk;
   longint      pin_sx, pin_sy;
   logic        pin_clip;
   logic [31:0] pin_dx, pin_dy;

   logic div_auto = 1'b1;
   int   man_req  = 0;
   int   man_ack  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   // Projection rules in plain 64-bit arithmetic.
   task automatic model(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        output logic near, output logic [31:0] dx, output logic [31:0] dy,
                        output longint sx, output longint sy, output logic clip);
      longint px, py, zz, fx, fy;
      near = $signed(z) < NEAR;
      zz   = longint'($signed(z));
      px   = longint'($signed(x)) * FOCAL;
      py   = longint'($signed(y)) * FOCAL;
      if (px > 64'sd2147483647)  px = 64'sd2147483647;
      if (px < -64'sd2147483647) px = -64'sd2147483647;
      if (py > 64'sd2147483647)  py = 64'sd2147483647;
      if (py < -64'sd2147483647) py = -64'sd2147483647;
      dx = px[31:0];
      dy = py[31:0];
      if (near) begin
         sx = 0; sy = 0; clip = 1'b1;
      end else begin
         fx   = SW / 2 + px / zz;
         fy   = SH / 2 - py / zz;
         clip = (fx < 0) || (fx > SW - 1) || (fy < 0) || (fy > SH - 1);
         sx   = (fx > 32767) ? 32767 : (fx < -32768) ? -32768 : fx;
         sy   = (fy > 32767) ? 32767 : (fy < -32768) ? -32768 : fy;
      end
   endtask

   // Divider emulation: random round trip of 1..5 cycles, plus manual stray pulses.
   initial begin : divider
      logic signed [31:0] a, b;
      int d;
      i_div_done     = 1'b0;
      i_div_quotient = '0;
      forever begin
         @(negedge i_clk);
         if (man_req != man_ack) begin
            man_ack = man_req;
            @(posedge i_clk); #1;
            i_div_done = 1'b1; i_div_quotient = 32'd5;
            @(posedge i_clk); #1;
            i_div_done = 1'b0;
         end else if (o_div_start && i_rst_n && div_auto) begin
            a = o_div_dividend;
            b = o_div_divisor;
            d = $urandom_range(1, 5);
            repeat (d) @(posedge i_clk);
            #1;
            i_div_done = 1'b1; i_div_quotient = a / b;
            @(posedge i_clk); #1;
            i_div_done = 1'b0;
         end
      end
   end

   // Per-cycle checker.
   initial begin : compare
      int          cyc, c0, st1, dn1, st2, dn2, vld_cyc;
      bit          busy;
      logic        exp_start, exp_valid;
      logic        m_near, m_clip;
      logic [31:0] m_dx, m_dy, m_z, obs_dx, obs_dy;
      longint      m_sx, m_sy;
      cyc = 0; busy = 0; c0 = 0;
      st1 = -1; dn1 = -1; st2 = -1; dn2 = -1;
      m_near = 0; m_clip = 0; m_dx = 0; m_dy = 0; m_z = 0; m_sx = 0; m_sy = 0;
      obs_dx = 0; obs_dy = 0;
      forever begin
         @(negedge i_clk);
         cyc++;
         if (!i_rst_n) begin
            chk("rst_ready", 64'(o_ready), 64'd1);
            chk("rst_ctl", 64'({o_valid, o_div_start, o_clip}), 64'd0);
            chk("rst_sxsy", 64'({o_sx, o_sy}), 64'd0);
            chk("rst_z", 64'(o_z), 64'd0);
            chk("rst_div", {o_div_dividend, o_div_divisor}, 64'd0);
            busy = 0; st1 = -1; dn1 = -1; st2 = -1; dn2 = -1;
            continue;
         end
         exp_start = busy && !m_near && (cyc == c0 + 1 || (dn1 >= 0 && st2 < 0 && cyc == dn1 + 1));
         chk("ready", 64'(o_ready), 64'(!busy));
         chk("div_start", 64'(o_div_start), 64'(exp_start));
         if (exp_start && st1 < 0) begin
            st1 = cyc; obs_dx = o_div_dividend;
         end else if (exp_start) begin
            st2 = cyc; obs_dy = o_div_dividend;
         end
         if (busy && st1 >= 0 && dn1 < 0) begin
            chk("dividend_x", 64'(o_div_dividend), 64'(m_dx));
            chk("divisor_x", 64'(o_div_divisor), 64'(m_z));
         end
         if (busy && st2 >= 0 && dn2 < 0) begin
            chk("dividend_y", 64'(o_div_dividend), 64'(m_dy));
            chk("divisor_y", 64'(o_div_divisor), 64'(m_z));
         end
         if (busy && i_div_done && st1 >= 0 && dn1 < 0 && cyc > st1) dn1 = cyc;
         else if (busy && i_div_done && st2 >= 0 && dn2 < 0 && cyc > st2) dn2 = cyc;
         if (m_near) vld_cyc = c0 + 1;
         else if (dn2 >= 0) vld_cyc = c0 + 3 + (dn1 - st1) + (dn2 - st2);
         else vld_cyc = 32'h7FFF_FFFF;
         exp_valid = busy && (cyc >= vld_cyc);
         chk("valid", 64'(o_valid), 64'(exp_valid));
         if (exp_valid) begin
            chk("sx", $signed(o_sx), m_sx);
            chk("sy", $signed(o_sy), m_sy);
            chk("z", 64'(o_z), 64'(m_z));
            chk("clip", 64'(o_clip), 64'(m_clip));
         end
         if (exp_valid && i_ready) begin
            if (pin_on) begin
               chk("pin_sx", $signed(o_sx), pin_sx);
               chk("pin_sy", $signed(o_sy), pin_sy);
               chk("pin_clip", 64'(o_clip), 64'(pin_clip));
               chk("pin_model_sx", m_sx, pin_sx);
               chk("pin_model_sy", m_sy, pin_sy);
               chk("pin_model_clip", 64'(m_clip), 64'(pin_clip));
               if (pin_dchk) begin
                  chk("pin_dx", 64'(obs_dx), 64'(pin_dx));
                  chk("pin_dy", 64'(obs_dy), 64'(pin_dy));
                  chk("pin_model_dx", 64'(m_dx), 64'(pin_dx));
               end
            end
            busy = 0;
         end else if (!busy && i_valid) begin
            model(i_x, i_y, i_z, m_near, m_dx, m_dy, m_sx, m_sy, m_clip);
            m_z = i_z; busy = 1; c0 = cyc;
            st1 = -1; dn1 = -1; st2 = -1; dn2 = -1;
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!o_ready) begin
         @(posedge i_clk); #1;
         if (++n > 500) begin
            $display("FAIL ready_timeout: o_ready stuck at %0d, expected 1", o_ready);
            $fatal(1, "ready timeout");
         end
      end
   endtask

   // mode 0: i_ready high, 1: random i_ready, 2: hold i_ready low 10 cycles in OUT
   task automatic run_vertex(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                             input int mode);
      int  n = 0, held = 0;
      bit  hs;
      wait_ready();
      i_x = x; i_y = y; i_z = z; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      forever begin
         if (o_valid) begin
            if (mode == 2 && held < 10) begin i_ready = 1'b0; held++; end
            else if (mode == 1) i_ready = ($urandom % 3) != 0;
            else i_ready = 1'b1;
         end
         hs = o_valid && i_ready;
         @(posedge i_clk); #1;
         if (hs) break;
         if (++n > 1000) begin
            $display("FAIL valid_timeout: o_valid stuck at %0d, expected 1", o_valid);
            $fatal(1, "valid timeout");
         end
      end
      i_ready = 1'b1;
   endtask

   task automatic run_pin(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input int mode, input longint sx, input longint sy, input logic clip,
                          input logic dchk, input logic [31:0] dx, input logic [31:0] dy);
      pin_sx = sx; pin_sy = sy; pin_clip = clip; pin_dchk = dchk; pin_dx = dx; pin_dy = dy;
      pin_on = 1'b1;
      run_vertex(x, y, z, mode);
      pin_on = 1'b0;
   endtask

   function automatic logic [31:0] rnd_coord();
      logic [31:0] r;
      r = $urandom;
      case ($urandom % 3)
         0:       return r;
         1:       return {{12{r[19]}}, r[19:0]};
         default: return {{16{r[15]}}, r[15:0]};
      endcase
   endfunction

   function automatic logic [31:0] rnd_depth();
      case ($urandom % 4)
         0:       return $urandom;
         1:       return $urandom_range(32'h0000_4000, 32'h0008_0000);
         2:       return NEAR + 32'($urandom_range(0, 2)) - 32'd1;
         default: return $urandom_range(32'h0000_4000, 32'h7FFF_FFFF);
      endcase
   endfunction

   initial begin : drive
      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      i_x = '0; i_y = '0; i_z = '0;
      repeat (3) @(posedge i_clk);
      #1 i_rst_n = 1'b1;

      run_pin(32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 0, 288, 56, 1'b0, 1'b1, 32'h0100_0000, 32'h0080_0000);
      run_pin(32'hFFFF_0000, 32'h0, 32'h0002_0000, 0, 32, 120, 1'b0, 1'b1, 32'hFF00_0000, 32'h0);
      run_pin(32'h0001_0000, 32'h0001_0000, 32'h0000_1000, 0, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
      run_pin(32'h7FFF_FFFF, 32'h0, 32'h0001_0000, 0, 32767, 120, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0);
      run_pin(32'h0002_0000, 32'h0, 32'h0001_0000, 0, 672, 120, 1'b1, 1'b1, 32'h0200_0000, 32'h0);
      run_pin(32'h0, 32'h0, 32'h0001_0000, 2, 160, 120, 1'b0, 1'b1, 32'h0, 32'h0);
      run_pin(32'hFFFF_6000, 32'h0, 32'h0001_0000, 0, 0, 120, 1'b0, 1'b1, 32'hFF60_0000, 32'h0);
      run_pin(32'h0000_9F00, 32'h0, 32'h0001_0000, 1, 319, 120, 1'b0, 1'b1, 32'h009F_0000, 32'h0);
      run_pin(32'h0000_A000, 32'h0, 32'h0001_0000, 0, 320, 120, 1'b1, 1'b1, 32'h00A0_0000, 32'h0);
      run_pin(32'h0, 32'h0000_7800, 32'h0001_0000, 0, 160, 0, 1'b0, 1'b1, 32'h0, 32'h0078_0000);
      run_pin(32'h0, 32'hFFFF_8800, 32'h0001_0000, 0, 160, 240, 1'b1, 1'b1, 32'h0, 32'hFF88_0000);
      run_pin(32'h0000_0040, 32'h0, 32'h0000_4000, 0, 161, 120, 1'b0, 1'b1, 32'h0000_4000, 32'h0);
      run_pin(32'h0001_0000, 32'h0, 32'h0000_3FFF, 0, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0);
      run_pin(32'h8000_0000, 32'h0, 32'h0001_0000, 0, -32607, 120, 1'b1, 1'b1, 32'h8000_0001, 32'h0);

      // Reset while waiting for the x quotient, then a stray done after release.
      div_auto = 1'b0;
      wait_ready();
      i_x = 32'h0001_0000; i_y = 32'h0; i_z = 32'h0002_0000; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      #1 i_rst_n = 1'b1;
      man_req++;
      repeat (6) @(posedge i_clk);
      #1 div_auto = 1'b1;

      for (int i = 0; i < 150; i++)
         run_vertex(rnd_coord(), rnd_coord(), rnd_depth(), int'($urandom % 2));

      repeat (5) @(posedge i_clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
